// File: rtl/alu_operand_loader.sv
// Operand front-end for the ALU: captures A, B and opcode from the switches,
// one value per debounced "next" press, then pulses start and holds the set.
module alu_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OPW             = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] sw,
    input  logic           btn_next,
    input  logic           btn_clear,
    output logic [OPW-1:0] portA,
    output logic [OPW-1:0] portB,
    output logic [1:0]     opcode,
    output logic [1:0]     stage,
    output logic           start,
    output logic           valid
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned NB = 2;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } state_e;

    // Button index 0 is next, 1 is clear.
    logic [NB-1:0] raw;
    logic [NB-1:0] s1_q, s2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic [NB-1:0] deb_dly_q;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] press;
    logic          next_p, clear_p;

    assign raw = {btn_clear, btn_next};

    // Accept a new level only after it has differed from the current one long enough.
    always_comb begin
        for (int i = 0; i < int'(NB); i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press   = deb_q & ~deb_dly_q;
    assign next_p  = press[0];
    assign clear_p = press[1];

    state_e         state_q, state_d;
    logic [OPW-1:0] porta_q, porta_d;
    logic [OPW-1:0] portb_q, portb_d;
    logic [1:0]     opcode_q, opcode_d;
    logic           start_q, start_d;
    logic           valid_q, valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD_A;
            porta_q  <= '0;
            portb_q  <= '0;
            opcode_q <= '0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            porta_q  <= porta_d;
            portb_q  <= portb_d;
            opcode_q <= opcode_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
        end
    end

    // Clear has priority over next; captured values persist through READY -> LOAD_A.
    always_comb begin
        state_d  = state_q;
        porta_d  = porta_q;
        portb_d  = portb_q;
        opcode_d = opcode_q;
        start_d  = 1'b0;
        if (clear_p) begin
            state_d  = LOAD_A;
            porta_d  = '0;
            portb_d  = '0;
            opcode_d = '0;
        end else if (next_p) begin
            case (state_q)
                LOAD_A: begin
                    porta_d = sw;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    portb_d = sw;
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    opcode_d = sw[1:0];
                    start_d  = 1'b1;
                    state_d  = READY;
                end
                default: state_d = LOAD_A;
            endcase
        end
        valid_d = (state_d == READY);
    end

    assign portA  = porta_q;
    assign portB  = portb_q;
    assign opcode = opcode_q;
    assign stage  = state_q;
    assign start  = start_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: a cycle-level behavioural model is
// compared on every falling edge, plus hand-computed literal expectations.
module tb_alu_operand_loader;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw;
    logic       btn_next, btn_clear;
    logic [2:0] portA, portB;
    logic [1:0] opcode, stage;
    logic       start, valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_seen = 0;
    bit chk_en = 0;

    alu_operand_loader #(.DEBOUNCE_CYCLES(D), .OPW(3)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
        .portA(portA), .portB(portB), .opcode(opcode), .stage(stage),
        .start(start), .valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: raw is seen two edges late; a level is accepted once the
    // delayed level has disagreed with the accepted one on D consecutive edges;
    // an accepted rising level is a press that acts on the following edge.
    int m_d1[2], m_d2[2], m_acc[2], m_run[2], m_press[2];
    int m_stage, m_A, m_B, m_op, m_start, m_valid;
    int pn, pc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                m_d1[b] = 0; m_d2[b] = 0; m_acc[b] = 0; m_run[b] = 0; m_press[b] = 0;
            end
            m_stage = 0; m_A = 0; m_B = 0; m_op = 0; m_start = 0; m_valid = 0;
        end else begin
            pn = m_press[0];
            pc = m_press[1];
            m_start = 0;
            if (pc != 0) begin
                m_stage = 0; m_A = 0; m_B = 0; m_op = 0;
            end else if (pn != 0) begin
                case (m_stage)
                    0: begin m_A = int'(sw); m_stage = 1; end
                    1: begin m_B = int'(sw); m_stage = 2; end
                    2: begin m_op = int'(sw) % 4; m_start = 1; m_stage = 3; end
                    default: m_stage = 0;
                endcase
            end
            m_valid = (m_stage == 3) ? 1 : 0;
            for (int b = 0; b < 2; b++) begin
                m_press[b] = 0;
                if (m_d2[b] != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_acc[b] = m_d2[b];
                        m_run[b] = 0;
                        m_press[b] = m_acc[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_d2[b] = m_d1[b];
            end
            m_d1[0] = int'(btn_next);
            m_d1[1] = int'(btn_clear);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("portA", int'(portA), m_A);
            check("portB", int'(portB), m_B);
            check("opcode", int'(opcode), m_op);
            check("stage", int'(stage), m_stage);
            check("start", int'(start), m_start);
            check("valid", int'(valid), m_valid);
            if (start) start_seen++;
        end
    end

    task automatic press_next(input logic [2:0] v);
        @(negedge clk);
        sw = v;
        btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_portA"}, int'(portA), 0);
        check({tag, "_portB"}, int'(portB), 0);
        check({tag, "_opcode"}, int'(opcode), 0);
        check({tag, "_stage"}, int'(stage), 0);
        check({tag, "_start"}, int'(start), 0);
        check({tag, "_valid"}, int'(valid), 0);
    endtask

    int s0;
    int t0;

    initial begin
        rst = 1'b0; sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        chk_en = 1;
        repeat (3) @(negedge clk);

        // Bounce: 2-high/2-low for 20 cycles, then hold high.
        sw = 3'd6;
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1; repeat (2) @(negedge clk);
            btn_next = 1'b0; repeat (2) @(negedge clk);
        end
        check("bounce_no_early_advance", int'(stage), 0);
        btn_next = 1'b1; repeat (10) @(negedge clk);
        btn_next = 1'b0; repeat (10) @(negedge clk);
        check("bounce_stage", int'(stage), 1);
        check("bounce_portA", int'(portA), 6);

        // Glitch shorter than the debounce window.
        btn_next = 1'b1; repeat (3) @(negedge clk);
        btn_next = 1'b0; repeat (10) @(negedge clk);
        check("glitch_stage", int'(stage), 1);
        check("glitch_portA", int'(portA), 6);

        // Clear back to LOAD_A.
        btn_clear = 1'b1; repeat (10) @(negedge clk);
        btn_clear = 1'b0; repeat (10) @(negedge clk);
        check("clear_stage", int'(stage), 0);
        check("clear_portA", int'(portA), 0);

        // Capture sequence 5, 3, 2 with start timing on the third press.
        press_next(3'd5);
        press_next(3'd3);
        s0 = start_seen;
        @(negedge clk);
        sw = 3'b010;
        btn_next = 1'b1;
        t0 = cyc;
        repeat (6) @(negedge clk);
        check("start_before_edge7", int'(start), 0);
        @(negedge clk);
        check("start_edge_index", cyc - t0, 7);
        check("start_at_edge7", int'(start), 1);
        @(negedge clk);
        check("start_after_edge7", int'(start), 0);
        repeat (2) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("start_pulse_count", start_seen - s0, 1);
        check("seq_portA", int'(portA), 5);
        check("seq_portB", int'(portB), 3);
        check("seq_opcode", int'(opcode), 2);
        check("seq_stage", int'(stage), 3);
        check("seq_valid", int'(valid), 1);

        // READY re-entry keeps operands until overwritten.
        press_next(3'd7);
        check("reentry_valid", int'(valid), 0);
        check("reentry_stage", int'(stage), 0);
        check("reentry_portA", int'(portA), 5);
        press_next(3'd1);
        check("reload_portA", int'(portA), 1);
        check("reload_stage", int'(stage), 1);
        press_next(3'd4);
        check("loadop_stage", int'(stage), 2);

        // Simultaneous clear and next in LOAD_OP: clear wins.
        s0 = start_seen;
        @(negedge clk);
        btn_next = 1'b1; btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0; btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        check("prio_stage", int'(stage), 0);
        check("prio_portA", int'(portA), 0);
        check("prio_portB", int'(portB), 0);
        check("prio_opcode", int'(opcode), 0);
        check("prio_no_start", start_seen - s0, 0);

        // Full sequence, then asynchronous mid-cycle reset.
        press_next(3'd5);
        press_next(3'd3);
        press_next(3'd2);
        check("pre_rst_stage", int'(stage), 3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        check_all_zero("held_rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_stage", int'(stage), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Input front-end for the ALU top. It produces the portA, portB and opcode values that the ALU consumes, taking them from board switches and pushbuttons.
- The user sets the switches and presses "next" three times to capture A, then B, then the opcode. After the third press the block issues a one-cycle start pulse and holds the captured values stable.
- Buttons are asynchronous, bouncy board inputs. Each is synchronised, debounced and edge-detected internally.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable clk cycles required before a synchronised button level is accepted (must be >= 2; board build overrides to 500000).
- OPW, 3, operand width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sw  input  OPW  switch value; sampled only on an accepted press.
- btn_next  input  1  raw pushbutton, active-high, asynchronous to clk.
- btn_clear  input  1  raw pushbutton, active-high, asynchronous to clk.
- portA  output  OPW  captured operand A (registered).
- portB  output  OPW  captured operand B (registered).
- opcode  output  2  captured opcode (sw[1:0]), registered.
- stage  output  2  current FSM state: 0=LOAD_A, 1=LOAD_B, 2=LOAD_OP, 3=READY.
- start  output  1  one-cycle pulse when opcode is captured.
- valid  output  1  high while the captured set is complete (stage==READY).

Behaviour:
- Reset: rst low forces the following immediately, asynchronously and regardless of clk:
  - portA=0, portB=0, opcode=0, stage=0, start=0, valid=0.
  - Synchroniser flops, debounced levels and debounce counters cleared to 0.
- Synchroniser: two flops per button, s1<=raw, s2<=s1.
- Debounce, per button:
  - Counter of width clog2(DEBOUNCE_CYCLES).
  - If s2==deb, counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1, deb<=s2 and counter<=0.
  - Else counter increments.
- Press detect: deb_d<=deb; press = deb & ~deb_d, combinational, high for exactly one cycle per accepted rising level.
- Latency: count the first rising edge that samples raw high as edge 1. If raw stays high, the FSM registers update on edge DEBOUNCE_CYCLES+3 (edge 7 for the default).
- Held button: produces one press only. Release must also be debounced before a new press is possible.
- FSM (next_p / clear_p are the press pulses):
  - LOAD_A: next_p -> portA<=sw, go LOAD_B.
  - LOAD_B: next_p -> portB<=sw, go LOAD_OP.
  - LOAD_OP: next_p -> opcode<=sw[1:0], start<=1 for one cycle, valid<=1, go READY.
  - READY: next_p -> valid<=0, go LOAD_A. portA, portB and opcode retain their values until overwritten.
  - Any state: clear_p -> portA, portB, opcode <= 0; valid<=0; start<=0; go LOAD_A.
- Simultaneous clear_p and next_p: clear wins. No capture and no start.
- start: registered and never high for two consecutive cycles. It is high only in the first cycle of READY.
- valid: registered, equivalent to (stage==3).
- Outputs change only on accepted presses or reset. sw changes between presses have no effect.

Test Plan:
- Reset: complete the full sequence, then drive rst low mid-cycle -> all outputs 0 before the next clk edge. They stay 0 while rst is low, and stage=0 after release.
- Capture sequence (DEBOUNCE_CYCLES=4): press with sw=5, then sw=3, then sw=3'b010, each held 10 cycles with gaps of 10 cycles.
  - After the third press: portA=5, portB=3, opcode=2, stage=3, valid=1.
  - start is high for exactly one cycle, beginning at edge 7 of the third press.
- Bounce: btn_next toggles every 2 cycles for 20 cycles, then holds high 10 cycles -> exactly one stage advance (0->1), portA=sw.
- Glitch: btn_next high for 3 cycles, then low -> no press; stage and portA unchanged.
- Clear priority: in LOAD_OP, assert btn_clear and btn_next on the same cycle for 10 cycles -> stage=0, portA=portB=opcode=0, start never asserted.
- READY re-entry: from READY with portA=5, press next -> valid=0, stage=0, portA still 5. Then press with sw=1 -> portA=1, stage=1.
